// File: rtl/repopulate_if.sv
// Bus between selection and fitness evaluation: start/done handshake plus
// the flat parent and population buses.
interface repopulate_if #(
  parameter int CHROM_W = 75,
  parameter int N_SEL   = 20,
  parameter int N_POP   = 100
);
  logic                       start;
  logic [N_SEL*CHROM_W-1:0]   sel_pop;
  logic [31:0]                prg_seed;
  logic [N_POP*CHROM_W-1:0]   pop;
  logic                       done;

  modport master (output start, sel_pop, prg_seed, input pop, done);
  modport slave  (input start, sel_pop, prg_seed, output pop, done);
endinterface

// File: rtl/repopulate.sv
// Rebuilds an N_POP population from N_SEL parents: elitist copy, then
// LFSR-driven single-point crossover with sparse mutation, one child per cycle.
module repopulate #(
  parameter int CHROM_W = 75,
  parameter int N_SEL   = 20,
  parameter int N_POP   = 100
) (
  input logic         clk,
  input logic         rst_n,
  repopulate_if.slave bus
);
  localparam int AW = $clog2(N_SEL);
  localparam int IW = $clog2(N_POP);
  localparam logic [5:0] SEL6 = 6'(N_SEL);
  localparam logic [6:0] CW7  = 7'(CHROM_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BREED = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                 r_state;
  logic [IW-1:0]              r_idx;
  logic [31:0]                r_lfsr;
  logic [N_SEL*CHROM_W-1:0]   r_parent;
  logic [N_POP*CHROM_W-1:0]   r_pop;
  logic                       r_done;

  logic [CHROM_W-1:0] w_par [N_SEL];
  logic [5:0]         w_aRaw, w_bRaw;
  logic [AW-1:0]      w_a, w_b;
  logic [6:0]         w_cp, w_mp;
  logic [CHROM_W-1:0] w_mask, w_cross, w_child;
  logic [31:0]        w_lfsrNext;

  for (genvar g = 0; g < N_SEL; g++) begin : g_par
    assign w_par[g] = r_parent[g*CHROM_W +: CHROM_W];
  end

  // Random fields come from the current LFSR; each is folded once into range.
  always_comb begin
    w_aRaw = {1'b0, r_lfsr[4:0]};
    if (w_aRaw >= SEL6) w_aRaw = w_aRaw - SEL6;
    w_bRaw = {1'b0, r_lfsr[9:5]};
    if (w_bRaw >= SEL6) w_bRaw = w_bRaw - SEL6;
    w_a = w_aRaw[AW-1:0];
    w_b = w_bRaw[AW-1:0];
    w_cp = r_lfsr[16:10];
    if (w_cp >= CW7) w_cp = w_cp - CW7;
    w_mp = r_lfsr[23:17];
    if (w_mp >= CW7) w_mp = w_mp - CW7;
    w_mask  = (CHROM_W'(1) << w_cp) - CHROM_W'(1);
    w_cross = (w_par[w_a] & w_mask) | (w_par[w_b] & ~w_mask);
    if (r_lfsr[27:24] == 4'd0) w_cross = w_cross ^ (CHROM_W'(1) << w_mp);
    w_child = (r_idx < IW'(N_SEL)) ? w_par[r_idx[AW-1:0]] : w_cross;
    w_lfsrNext = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_lfsr   <= 32'h1;
      r_parent <= '0;
      r_pop    <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_parent <= bus.sel_pop;
            r_lfsr   <= (bus.prg_seed == 32'h0) ? 32'h1 : bus.prg_seed;
            r_idx    <= '0;
            r_state  <= S_BREED;
          end
        end
        S_BREED: begin
          for (int i = 0; i < N_POP; i++) begin
            if (r_idx == IW'(i)) r_pop[i*CHROM_W +: CHROM_W] <= w_child;
          end
          if (r_idx >= IW'(N_SEL)) r_lfsr <= w_lfsrNext;
          if (r_idx == IW'(N_POP-1)) r_state <= S_DONE;
          else                       r_idx   <= r_idx + 1'b1;
        end
        S_DONE: begin
          // done is guaranteed to be visible for at least one cycle before release
          r_done <= 1'b1;
          if (r_done && !bus.start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pop  = r_pop;
  assign bus.done = r_done;
endmodule
